// File: rtl/sy_pkg.sv
// Shared types and constants for the fetch-side BTB and its retire-side update port.
package sy_pkg;

    localparam int unsigned AWTH          = 32;
    localparam int unsigned BTB_INDEX_LSB = 4;

    typedef struct packed {
        logic            vld;
        logic [AWTH-1:0] pc;
        logic [AWTH-1:0] target_address;
    } btb_update_t;

    typedef struct packed {
        logic [AWTH-1:0] pc;
        logic            taken;
        logic [AWTH-1:0] target;
        logic            pred_vld;
        logic [AWTH-1:0] pred_target;
    } btb_resolve_t;

    // A BTB write is only useful for a taken branch the BTB missed or mispredicted.
    function automatic logic btb_needs_update(btb_resolve_t r);
        return r.taken & (~r.pred_vld | (r.pred_target != r.target));
    endfunction

endpackage

// File: rtl/sy_ppl_btb_upd_q.sv
// Retire-side BTB update queue: filters useless updates, coalesces same-index writes at the
// tail, and drains one update per cycle into the BTB write port.
module sy_ppl_btb_upd_q
    import sy_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BTB_ENTRIES = 512,
    parameter int unsigned CNT_WTH     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btb_flush_i,
    input  logic               res_vld_i,
    output logic               res_rdy_o,
    input  logic [AWTH-1:0]    res_pc_i,
    input  logic               res_taken_i,
    input  logic [AWTH-1:0]    res_target_i,
    input  logic               res_pred_vld_i,
    input  logic [AWTH-1:0]    res_pred_target_i,
    input  logic               btb_wr_stall_i,
    output btb_update_t        btb_update_o,
    output logic [31:0]        upd_cnt_o,
    output logic [CNT_WTH-1:0] drop_cnt_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned IdxW   = $clog2(BTB_ENTRIES);
    localparam int unsigned DropSW = CNT_WTH + 1;

    function automatic logic [IdxW-1:0] btb_idx(logic [AWTH-1:0] pc);
        return pc[BTB_INDEX_LSB +: IdxW];
    endfunction

    logic [AWTH-1:0]    mem_pc_q  [DEPTH];
    logic [AWTH-1:0]    mem_tgt_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
    logic [CntW-1:0]    count_q, count_d;
    btb_update_t        upd_q, upd_d;
    logic [31:0]        upd_cnt_q, upd_cnt_d;
    logic [CNT_WTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [DropSW-1:0]  drop_sum;

    btb_resolve_t res;
    logic         full, accept, need, pop, tail_hit, coalesce, push;

    always_comb begin
        res = '{pc: res_pc_i, taken: res_taken_i, target: res_target_i,
                pred_vld: res_pred_vld_i, pred_target: res_pred_target_i};
        need      = btb_needs_update(res);
        full      = count_q == CntW'(DEPTH);
        res_rdy_o = ~full & ~btb_flush_i;
        accept    = res_vld_i & res_rdy_o;
        pop       = (count_q != '0) & ~btb_wr_stall_i & ~btb_flush_i;
        tail_ptr  = wr_ptr_q - 1'b1;
        tail_hit  = btb_idx(mem_pc_q[tail_ptr]) == btb_idx(res_pc_i);
        // The tail can only be rewritten if it is not leaving the queue this cycle.
        coalesce  = accept & need & (count_q != '0) & tail_hit
                    & ((count_q >= CntW'(2)) | ~pop);
        push      = accept & need & ~coalesce;

        wr_ptr_d  = wr_ptr_q + PtrW'(push);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        count_d   = count_q + CntW'(push) - CntW'(pop);

        upd_d     = upd_q;
        upd_d.vld = pop;
        if (pop) begin
            upd_d.pc             = mem_pc_q[rd_ptr_q];
            upd_d.target_address = mem_tgt_q[rd_ptr_q];
        end

        upd_cnt_d  = (pop && upd_cnt_q != '1) ? upd_cnt_q + 32'd1 : upd_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + DropSW'(count_q);
        drop_cnt_d = drop_sum[CNT_WTH] ? '1 : drop_sum[CNT_WTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            upd_q      <= '0;
            upd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (btb_flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            upd_q.vld  <= 1'b0;
            drop_cnt_q <= drop_cnt_d;
        end else begin
            if (push) begin
                mem_pc_q[wr_ptr_q]  <= res_pc_i;
                mem_tgt_q[wr_ptr_q] <= res_target_i;
            end
            if (coalesce) begin
                mem_pc_q[tail_ptr]  <= res_pc_i;
                mem_tgt_q[tail_ptr] <= res_target_i;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            upd_q     <= upd_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign btb_update_o = upd_q;
    assign upd_cnt_o    = upd_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_sy_ppl_btb_upd_q.sv
// Directed bench for the BTB update queue: filtering, latency, coalescing, backpressure,
// flush accounting and mid-run reset.
module tb_sy_ppl_btb_upd_q;
    import sy_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               res_vld = 1'b0;
    logic               res_rdy;
    logic [AWTH-1:0]    res_pc = '0;
    logic               res_taken = 1'b0;
    logic [AWTH-1:0]    res_target = '0;
    logic               res_pred_vld = 1'b0;
    logic [AWTH-1:0]    res_pred_target = '0;
    logic               stall = 1'b0;
    btb_update_t        upd;
    logic [31:0]        upd_cnt;
    logic [15:0]        drop_cnt;

    int checks = 0;
    int errors = 0;
    btb_update_t got_q[$];

    sy_ppl_btb_upd_q #(.DEPTH(4), .BTB_ENTRIES(512), .CNT_WTH(16)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .btb_flush_i       (flush),
        .res_vld_i         (res_vld),
        .res_rdy_o         (res_rdy),
        .res_pc_i          (res_pc),
        .res_taken_i       (res_taken),
        .res_target_i      (res_target),
        .res_pred_vld_i    (res_pred_vld),
        .res_pred_target_i (res_pred_target),
        .btb_wr_stall_i    (stall),
        .btb_update_o      (upd),
        .upd_cnt_o         (upd_cnt),
        .drop_cnt_o        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (upd.vld) got_q.push_back(upd);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic pv, input logic [31:0] pt);
        res_pc = pc; res_target = tgt; res_taken = tk; res_pred_vld = pv; res_pred_target = pt;
    endtask

    // Hold the transfer until accepted, bounded.
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic pv, input logic [31:0] pt);
        set_res(pc, tgt, tk, pv, pt);
        res_vld = 1'b1;
        #1;
        for (int i = 0; i < 50 && !res_rdy; i++) tick();
        if (!res_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got rdy 0 expected 1 (pc %0h)", pc);
        end
        tick();
        res_vld = 1'b0;
    endtask

    task automatic check_upd(input string tag, input int k, input logic [31:0] pc,
                             input logic [31:0] tgt);
        if (k < got_q.size()) begin
            check({tag, "_pc"}, 64'(got_q[k].pc), 64'(pc));
            check({tag, "_tgt"}, 64'(got_q[k].target_address), 64'(tgt));
        end else begin
            check({tag, "_present"}, 64'(got_q.size()), 64'(k + 1));
        end
    endtask

    initial begin
        logic [31:0] pcs [5];
        logic [31:0] tgs [5];
        pcs = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1040};
        tgs = '{32'h5000, 32'h5100, 32'h5200, 32'h5300, 32'h5400};

        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_vld", 64'(upd.vld), 64'd0);
        check("rst_upd_cnt", 64'(upd_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_rdy", 64'(res_rdy), 64'd1);

        // 1: mispredicted taken branch appears two cycles after acceptance
        got_q.delete();
        send(32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0);
        check("t1_vld_n1", 64'(upd.vld), 64'd0);
        tick();
        check("t1_vld_n2", 64'(upd.vld), 64'd1);
        check("t1_pc", 64'(upd.pc), 64'h1000);
        check("t1_tgt", 64'(upd.target_address), 64'h2000);
        check("t1_upd_cnt", 64'(upd_cnt), 64'd1);
        tick();
        check("t1_vld_n3", 64'(upd.vld), 64'd0);

        // 2: correctly predicted and not-taken are consumed without an update
        got_q.delete();
        send(32'h1000, 32'h2000, 1'b1, 1'b1, 32'h2000);
        check("t2_rdy_a", 64'(res_rdy), 64'd1);
        send(32'h1040, 32'h9000, 1'b0, 1'b0, 32'h0);
        check("t2_rdy_b", 64'(res_rdy), 64'd1);
        repeat (4) tick();
        check("t2_no_upd", 64'(got_q.size()), 64'd0);
        check("t2_upd_cnt", 64'(upd_cnt), 64'd1);

        // 3: third push shares index 0x101 with the tail and replaces it
        got_q.delete();
        stall = 1'b1;
        send(32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0);
        send(32'h1010, 32'h3000, 1'b1, 1'b0, 32'h0);
        send(32'h3010, 32'h4000, 1'b1, 1'b0, 32'h0);
        stall = 1'b0;
        repeat (6) tick();
        check("t3_count", 64'(got_q.size()), 64'd2);
        check_upd("t3_u0", 0, 32'h1000, 32'h2000);
        check_upd("t3_u1", 1, 32'h3010, 32'h4000);

        // 4: full queue back-pressures; no push-through while a pop frees a slot
        got_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) send(pcs[i], tgs[i], 1'b1, 1'b0, 32'h0);
        check("t4_full_rdy", 64'(res_rdy), 64'd0);
        set_res(pcs[4], tgs[4], 1'b1, 1'b0, 32'h0);
        res_vld = 1'b1;
        stall = 1'b0;
        #1;
        check("t4_pop_full_rdy", 64'(res_rdy), 64'd0);
        tick();
        check("t4_after_pop_rdy", 64'(res_rdy), 64'd1);
        tick();
        res_vld = 1'b0;
        repeat (8) tick();
        check("t4_count", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) check_upd($sformatf("t4_u%0d", i), i, pcs[i], tgs[i]);
        check("t4_upd_cnt", 64'(upd_cnt), 64'd8);

        // 5: flush discards queued work and counts it
        got_q.delete();
        stall = 1'b1;
        send(32'h2000, 32'h6000, 1'b1, 1'b0, 32'h0);
        send(32'h2010, 32'h6100, 1'b1, 1'b0, 32'h0);
        send(32'h2020, 32'h6200, 1'b1, 1'b0, 32'h0);
        set_res(32'h2030, 32'h6300, 1'b1, 1'b0, 32'h0);
        res_vld = 1'b1;
        flush = 1'b1;
        #1;
        check("t5_flush_rdy", 64'(res_rdy), 64'd0);
        tick();
        flush = 1'b0;
        res_vld = 1'b0;
        stall = 1'b0;
        #1;
        check("t5_drop_cnt", 64'(drop_cnt), 64'd3);
        check("t5_rdy", 64'(res_rdy), 64'd1);
        repeat (6) tick();
        check("t5_no_upd", 64'(got_q.size()), 64'd0);
        check("t5_upd_cnt", 64'(upd_cnt), 64'd8);

        // 6: reset mid-operation drops everything; next push works normally
        got_q.delete();
        stall = 1'b1;
        send(32'h3000, 32'h7000, 1'b1, 1'b0, 32'h0);
        send(32'h3010, 32'h7100, 1'b1, 1'b0, 32'h0);
        stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_vld", 64'(upd.vld), 64'd0);
        check("t6_upd_cnt", 64'(upd_cnt), 64'd0);
        check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (5) tick();
        check("t6_no_upd", 64'(got_q.size()), 64'd0);
        send(32'h4000, 32'h4100, 1'b1, 1'b0, 32'h0);
        repeat (3) tick();
        check("t6_count", 64'(got_q.size()), 64'd1);
        check_upd("t6_u0", 0, 32'h4000, 32'h4100);
        check("t6_upd_cnt_after", 64'(upd_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
